// File: rtl/gb_oam_pkg.sv
// Shared types and constants for the Game Boy OAM DMA engine.
// GB_OAM_DMA_ECHO_MAP_EN remaps source pages 0xE0..0xFF onto the WRAM echo at 0xC0..0xDF.
package gb_oam_pkg;

  localparam int unsigned OAM_BYTES = 160;
  localparam logic [15:0] OAM_BASE  = 16'hFE00;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_DELAY,
    DMA_READ,
    DMA_HOLD
  } oam_dma_state_t;

  function automatic logic [7:0] map_src_page(input logic [7:0] page);
`ifdef GB_OAM_DMA_ECHO_MAP_EN
    return (page >= 8'hE0) ? (page - 8'h20) : page;
`else
    return page;
`endif
  endfunction

endpackage

// File: rtl/gb_oam_dma.sv
// OAM DMA engine: copies one source page into OAM through a req/ack read port.
// Optional GB_OAM_DMA_ECHO_MAP_EN (see gb_oam_pkg) remaps echo-RAM source pages.
module gb_oam_dma
  import gb_oam_pkg::*;
#(
  parameter int unsigned OamBytes   = OAM_BYTES,
  parameter int unsigned SlotCycles = 4,
  parameter int unsigned StartDelay = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dma_start_i,
  input  logic [15:0] dma_start_addr_i,
  output logic        rd_req_o,
  output logic [15:0] rd_addr_o,
  input  logic [7:0]  rd_data_i,
  input  logic        rd_ack_i,
  output logic        oam_we_o,
  output logic [7:0]  oam_addr_o,
  output logic [7:0]  oam_wdata_o,
  output logic        dma_active_o,
  output logic        dma_done_o
);

  localparam int unsigned IdxW    = $clog2(OamBytes);
  localparam int unsigned TcntMax = (SlotCycles > StartDelay) ? SlotCycles : StartDelay;
  localparam int unsigned TcntW   = (TcntMax > 2) ? $clog2(TcntMax) : 1;

  localparam logic [IdxW-1:0]  IdxLast   = IdxW'(OamBytes - 1);
  localparam logic [TcntW-1:0] SlotLast  = TcntW'(SlotCycles - 1);
  localparam logic [TcntW-1:0] DelayLast = TcntW'(StartDelay - 1);

  oam_dma_state_t   state_q;
  logic [IdxW-1:0]  idx_q;
  logic [TcntW-1:0] tcnt_q;
  logic [7:0]       page_q;
  logic [7:0]       data_q;
  logic             done_q;

  logic [TcntW-1:0] tcnt_sat;
  logic             unused_addr;

  assign tcnt_sat    = (tcnt_q == SlotLast) ? tcnt_q : tcnt_q + 1'b1;
  assign unused_addr = ^dma_start_addr_i[7:0];

  // A start request always wins, including over a write that is due this cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DMA_IDLE;
      idx_q   <= '0;
      tcnt_q  <= '0;
      page_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (dma_start_i) begin
        page_q  <= map_src_page(dma_start_addr_i[15:8]);
        idx_q   <= '0;
        tcnt_q  <= '0;
        state_q <= DMA_DELAY;
      end else begin
        unique case (state_q)
          DMA_DELAY: begin
            if (tcnt_q == DelayLast) begin
              tcnt_q  <= '0;
              state_q <= DMA_READ;
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
          DMA_READ: begin
            tcnt_q <= tcnt_sat;
            if (rd_ack_i) begin
              data_q  <= rd_data_i;
              state_q <= DMA_HOLD;
            end
          end
          DMA_HOLD: begin
            if (tcnt_q == SlotLast) begin
              tcnt_q <= '0;
              if (idx_q == IdxLast) begin
                idx_q   <= '0;
                done_q  <= 1'b1;
                state_q <= DMA_IDLE;
              end else begin
                idx_q   <= idx_q + 1'b1;
                state_q <= DMA_READ;
              end
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rd_req_o     = (state_q == DMA_READ);
  assign rd_addr_o    = {page_q, 8'(idx_q)};
  assign oam_we_o     = (state_q == DMA_HOLD) && (tcnt_q == SlotLast) && !dma_start_i;
  assign oam_addr_o   = 8'(idx_q);
  assign oam_wdata_o  = data_q;
  assign dma_active_o = (state_q != DMA_IDLE);
  assign dma_done_o   = done_q;

endmodule

// File: tb/tb_gb_oam_dma.sv
// Self-checking bench for gb_oam_dma: transaction-level timing model plus directed/random runs.
module tb_gb_oam_dma;
  import gb_oam_pkg::*;

  localparam int H          = 1600;
  localparam int StartDelay = 4;
  localparam int SlotCycles = 4;

  logic        clk;
  logic        rst_n;
  logic        dma_start;
  logic [15:0] dma_start_addr;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic        rd_ack;
  logic        oam_we;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        dma_active;
  logic        dma_done;

  gb_oam_dma dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .dma_start_i     (dma_start),
    .dma_start_addr_i(dma_start_addr),
    .rd_req_o        (rd_req),
    .rd_addr_o       (rd_addr),
    .rd_data_i       (rd_data),
    .rd_ack_i        (rd_ack),
    .oam_we_o        (oam_we),
    .oam_addr_o      (oam_addr),
    .oam_wdata_o     (oam_wdata),
    .dma_active_o    (dma_active),
    .dma_done_o      (dma_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem    [0:65535];
  logic [7:0]  oam_sh [0:255];
  int unsigned dly    [OAM_BYTES];

  bit          st_en   [H];
  logic [7:0]  st_page [H];
  bit          rst_en  [H];

  bit          e_rq  [H];
  bit          e_we  [H];
  bit          e_act [H];
  bit          e_dn  [H];
  logic [15:0] e_ra  [H];
  logic [7:0]  e_oa  [H];
  logic [7:0]  e_od  [H];

  int          tests, fails;
  int          done_cnt, we_cnt, first_done;
  bit          got_ra;
  logic [15:0] first_ra;

  function automatic logic [7:0] exp_page(input logic [7:0] p);
`ifdef GB_OAM_DMA_ECHO_MAP_EN
    return (p >= 8'hE0) ? (p - 8'h20) : p;
`else
    return p;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic plan_clear();
    for (int c = 0; c < H; c++) begin
      st_en[c]   = 1'b0;
      st_page[c] = 8'h00;
      rst_en[c]  = 1'b0;
    end
    rst_en[0] = 1'b1;
    rst_en[1] = 1'b1;
    for (int k = 0; k < OAM_BYTES; k++) dly[k] = 0;
  endtask

  // Each start launches a transfer that runs until the next start or reset.
  // Byte k: read window [rs, rs+dly], written at max(rs+Slot-1, ack+1), next read at write+1.
  task automatic build_model(input int n);
    int lim, rs, ack, w, last, hi;
    bit by_rst, fin;
    logic [7:0] pg;
    for (int c = 0; c < H; c++) begin
      e_rq[c] = 0; e_we[c] = 0; e_act[c] = 0; e_dn[c] = 0;
      e_ra[c] = '0; e_oa[c] = '0; e_od[c] = '0;
    end
    for (int s = 0; s < n; s++) begin
      if (st_en[s] && !rst_en[s]) begin
        lim    = n + 4000;
        by_rst = 1'b0;
        for (int c = s + 1; c < n; c++) begin
          if (rst_en[c] || st_en[c]) begin
            lim    = c;
            by_rst = rst_en[c];
            break;
          end
        end
        pg   = exp_page(st_page[s]);
        rs   = s + 1 + StartDelay;
        last = -1;
        fin  = 1'b1;
        for (int k = 0; k < OAM_BYTES; k++) begin
          ack = rs + int'(dly[k]);
          w   = (rs + SlotCycles - 1 > ack + 1) ? rs + SlotCycles - 1 : ack + 1;
          for (int c = rs; c <= ack && c < n; c++) begin
            if (c < lim || (c == lim && !by_rst)) begin
              e_rq[c] = 1'b1;
              e_ra[c] = {pg, 8'(k)};
            end
          end
          if (w >= lim) begin
            fin = 1'b0;
            break;
          end
          if (w < n) begin
            e_we[w] = 1'b1;
            e_oa[w] = 8'(k);
            e_od[w] = mem[{pg, 8'(k)}];
          end
          last = w;
          rs   = w + 1;
        end
        if (fin) begin
          if (last + 1 < n) e_dn[last + 1] = 1'b1;
          for (int c = s + 1; c <= last && c < n; c++) e_act[c] = 1'b1;
        end else begin
          hi = by_rst ? lim - 1 : lim;
          for (int c = s + 1; c <= hi && c < n; c++) e_act[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic run(input int n);
    int rq_cnt;
    logic [35:0] obs, exp;
    build_model(n);
    rq_cnt     = 0;
    done_cnt   = 0;
    we_cnt     = 0;
    first_done = -1;
    got_ra     = 1'b0;
    first_ra   = '0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rst_n          = !rst_en[c];
      dma_start      = st_en[c];
      dma_start_addr = {st_page[c], 8'($urandom)};
      #1;
      // Memory responder; stray acks with junk data while no read is pending.
      if (rd_req) begin
        if (rq_cnt == int'(dly[rd_addr[7:0]])) begin
          rd_ack  = 1'b1;
          rd_data = mem[rd_addr];
        end else begin
          rd_ack  = 1'b0;
          rd_data = 8'($urandom);
        end
      end else begin
        rd_ack  = ($urandom_range(2) == 0);
        rd_data = 8'($urandom);
      end
      #1;
      if (rst_en[c]) begin
        obs = {rd_req, rd_addr, oam_we, oam_addr, oam_wdata, dma_active, dma_done};
        exp = '0;
      end else begin
        obs = {rd_req, rd_req ? rd_addr : 16'h0, oam_we, oam_we ? oam_addr : 8'h0,
               oam_we ? oam_wdata : 8'h0, dma_active, dma_done};
        exp = {e_rq[c], e_rq[c] ? e_ra[c] : 16'h0, e_we[c], e_we[c] ? e_oa[c] : 8'h0,
               e_we[c] ? e_od[c] : 8'h0, e_act[c], e_dn[c]};
      end
      chk($sformatf("cyc%0d", c), 64'(obs), 64'(exp));
      if (dma_done) begin
        done_cnt++;
        if (first_done < 0) first_done = c;
      end
      if (oam_we) begin
        we_cnt++;
        oam_sh[oam_addr] = oam_wdata;
      end
      if (rd_req && !got_ra) begin
        got_ra   = 1'b1;
        first_ra = rd_addr;
      end
      rq_cnt = (rd_req && !rd_ack) ? rq_cnt + 1 : 0;
    end
  endtask

  initial begin
    logic [7:0] pg;
    int b;
    tests          = 0;
    fails          = 0;
    rst_n          = 1'b0;
    dma_start      = 1'b0;
    dma_start_addr = '0;
    rd_ack         = 1'b0;
    rd_data        = '0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int k = 0; k < OAM_BYTES; k++) mem[{8'hC1, 8'(k)}] = 8'(k) ^ 8'h5A;
    for (int a = 0; a < 256; a++) oam_sh[a] = 8'h00;
    #1;
    chk("reset_outputs",
        64'({rd_req, rd_addr, oam_we, oam_addr, oam_wdata, dma_active, dma_done}), 64'h0);

    // Zero-wait copy of page 0xC1.
    plan_clear();
    st_en[3] = 1'b1; st_page[3] = 8'hC1;
    run(660);
    chk("t1_done_cycle", 64'(first_done), 64'(3 + 645));
    chk("t1_done_count", 64'(done_cnt), 64'd1);
    chk("t1_write_count", 64'(we_cnt), 64'd160);
    for (int k = 0; k < OAM_BYTES; k += 16)
      chk($sformatf("t1_oam%0d", k), 64'(oam_sh[k]), 64'(8'(k) ^ 8'h5A));

    // Ack for byte 3 held off for 6 cycles: whole tail slips by 4 cycles.
    plan_clear();
    dly[3] = 6;
    st_en[3] = 1'b1; st_page[3] = 8'hC1;
    run(670);
    chk("t2_done_cycle", 64'(first_done), 64'(3 + 645 + 4));
    chk("t2_write_count", 64'(we_cnt), 64'd160);
    chk("t2_oam3", 64'(oam_sh[3]), 64'(8'h03 ^ 8'h5A));

    // Restart with page 0xD0 one cycle before byte 80 is written.
    plan_clear();
    st_en[3] = 1'b1;   st_page[3] = 8'hC1;
    st_en[330] = 1'b1; st_page[330] = 8'hD0;
    run(990);
    chk("t3_done_count", 64'(done_cnt), 64'd1);
    chk("t3_done_cycle", 64'(first_done), 64'(330 + 645));

    // Reset in the middle of byte 50, then a fresh transfer.
    plan_clear();
    st_en[3] = 1'b1; st_page[3] = 8'hC1;
    rst_en[210] = 1'b1; rst_en[211] = 1'b1; rst_en[212] = 1'b1;
    st_en[220] = 1'b1; st_page[220] = 8'h45;
    run(880);
    chk("t4_done_count", 64'(done_cnt), 64'd1);
    chk("t4_done_cycle", 64'(first_done), 64'(220 + 645));

    // Echo-area page.
    plan_clear();
    st_en[3] = 1'b1; st_page[3] = 8'hFE;
    run(40);
`ifdef GB_OAM_DMA_ECHO_MAP_EN
    chk("t5_first_rd_addr", 64'(first_ra), 64'h0000_DE00);
`else
    chk("t5_first_rd_addr", 64'(first_ra), 64'h0000_FE00);
`endif

    // Random pages, random ack latency, and a held-high start burst mid-transfer.
    for (int it = 0; it < 2; it++) begin
      plan_clear();
      for (int k = 0; k < OAM_BYTES; k++)
        dly[k] = ($urandom_range(3) == 0) ? $urandom_range(7) : 0;
      pg = 8'($urandom);
      st_en[3] = 1'b1; st_page[3] = pg;
      b  = $urandom_range(500, 100);
      pg = 8'($urandom);
      for (int j = 0; j < 3; j++) begin
        st_en[b + j]   = 1'b1;
        st_page[b + j] = pg;
      end
      run(1500);
      chk($sformatf("t6_done_count_%0d", it), 64'(done_cnt), 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
